// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register:
// opcodes and FSM state encoding.
package univ_shift_pkg;

   localparam logic [2:0] OP_HOLD  = 3'd0;
   localparam logic [2:0] OP_SHR   = 3'd1;
   localparam logic [2:0] OP_SHL   = 3'd2;
   localparam logic [2:0] OP_ROTR  = 3'd3;
   localparam logic [2:0] OP_ROTL  = 3'd4;
   localparam logic [2:0] OP_ASR   = 3'd5;
   localparam logic [2:0] OP_LOAD  = 3'd6;
   localparam logic [2:0] OP_CLEAR = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/univ_shift_seq_if.sv
// Command/status bundle of the universal shift register.
// master drives commands, slave is the register itself.
interface univ_shift_seq_if #(
   parameter int N = 8
);
   localparam int AW = $clog2(N);

   logic          start;
   logic [2:0]    opr;
   logic [AW-1:0] amt;
   logic [N-1:0]  din;
   logic          sin_r;
   logic          sin_l;
   logic [N-1:0]  q;
   logic          sout_r;
   logic          sout_l;
   logic          busy;
   logic          done;

   modport master (
      output start, opr, amt, din, sin_r, sin_l,
      input  q, sout_r, sout_l, busy, done
   );

   modport slave (
      input  start, opr, amt, din, sin_r, sin_l,
      output q, sout_r, sout_l, busy, done
   );

endinterface

// File: rtl/univ_shift_seq_shift_step.sv
// Single-step combinational shifter; non-shift opcodes
// pass q through unchanged.
module shift_step
   import univ_shift_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] q,
   input  logic         sin_r,
   input  logic         sin_l,
   output logic [N-1:0] q_next
);

   // one bit of movement for the selected opcode
   always_comb begin
      q_next = q;
      case (op)
         OP_SHR:  q_next = {sin_r, q[N-1:1]};
         OP_SHL:  q_next = {q[N-2:0], sin_l};
         OP_ROTR: q_next = {q[0], q[N-1:1]};
         OP_ROTL: q_next = {q[N-2:0], q[N-1]};
         OP_ASR:  q_next = {q[N-1], q[N-1:1]};
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register: multi-bit shifts run one bit
// per clock under a two-state FSM with busy/done handshake.
module univ_shift_seq
   import univ_shift_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   univ_shift_seq_if.slave bus
);

   localparam int AW = $clog2(N);

   state_t        state, state_n;
   logic [N-1:0]  q, q_n, q_step;
   logic [AW-1:0] cnt, cnt_n;
   logic [2:0]    op_r, op_n;
   logic          busy, busy_n;
   logic          done, done_n;
   logic          is_shift;

   shift_step #(.N(N)) u_step (
      .op     (op_r),
      .q      (q),
      .sin_r  (bus.sin_r),
      .sin_l  (bus.sin_l),
      .q_next (q_step)
   );

   assign is_shift = (bus.opr != OP_HOLD) &&
                     (bus.opr != OP_LOAD) &&
                     (bus.opr != OP_CLEAR);

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         q     <= '0;
         cnt   <= '0;
         op_r  <= OP_HOLD;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         q     <= q_n;
         cnt   <= cnt_n;
         op_r  <= op_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   // command acceptance in IDLE, one step per edge in RUN
   always_comb begin
      state_n = state;
      q_n     = q;
      cnt_n   = cnt;
      op_n    = op_r;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.opr == OP_LOAD) begin
                  q_n    = bus.din;
                  done_n = 1'b1;
               end else if (bus.opr == OP_CLEAR) begin
                  q_n    = '0;
                  done_n = 1'b1;
               end else if (!is_shift || bus.amt == '0) begin
                  done_n = 1'b1;
               end else begin
                  op_n    = bus.opr;
                  cnt_n   = bus.amt;
                  busy_n  = 1'b1;
                  state_n = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            q_n    = q_step;
            cnt_n  = cnt - AW'(1);
            busy_n = 1'b1;
            if (cnt == AW'(1)) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.q      = q;
   assign bus.sout_r = q[0];
   assign bus.sout_l = q[N-1];
   assign bus.busy   = busy;
   assign bus.done   = done;

endmodule

// File: doc/univ_shift_seq.md
Name: univ_shift_seq

Overview:
Parametrised universal shift register. Generalises the single-mode right-shift register to eight operations: shift, rotate, arithmetic shift, parallel load and clear. A multi-bit shift amount is executed one bit per clock, sequenced by a small FSM with a start/busy/done handshake. It serves as the shift/serialise datapath element for controllers in the Sequential library.

Parameters:
N, 8, register width in bits (N >= 2)
AW, $clog2(N), width of the shift-amount field (derived; not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
start  in  1  command strobe; sampled only when busy=0
opr  in  3  operation code, captured with start
amt  in  AW  shift/rotate distance, 0..N-1, captured with start
din  in  N  parallel load data, used by LOAD only
sin_r  in  1  serial input entering the MSB on SHR
sin_l  in  1  serial input entering the LSB on SHL
q  out  N  register contents (registered)
sout_r  out  1  q[0], combinational from q
sout_l  out  1  q[N-1], combinational from q
busy  out  1  high while a multi-cycle shift is in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0 at a clk edge): q=0, busy=0, done=0, FSM to IDLE. Reset overrides any in-flight command; no done pulse is issued for an aborted command.
- Opcodes: 0 HOLD, 1 SHR, 2 SHL, 3 ROTR, 4 ROTL, 5 ASR, 6 LOAD, 7 CLEAR.
- Single-step operations:
  - SHR: q <= {sin_r, q[N-1:1]}
  - SHL: q <= {q[N-2:0], sin_l}
  - ROTR: q <= {q[0], q[N-1:1]}
  - ROTL: q <= {q[N-2:0], q[N-1]}
  - ASR: q <= {q[N-1], q[N-1:1]}
- FSM states: IDLE, RUN.
- IDLE behaviour:
  - start=1 with opr=LOAD: q<=din at the same edge.
  - start=1 with opr=CLEAR: q<=0 at the same edge.
  - start=1 with opr=HOLD, or with a shift/rotate opcode and amt=0: q unchanged.
  - In all four cases above: done=1 for the following cycle, busy stays 0, FSM stays IDLE.
  - start=1 with a shift/rotate opcode and amt=k>=1: capture opr into op_r and load cnt=k. Set busy=1, go to RUN. q is unchanged at this edge (edge E0).
- RUN behaviour:
  - Each edge applies one step of op_r and decrements cnt. Edges E1..Ek perform the k steps.
  - At Ek (cnt=1): busy<=0, done<=1, go to IDLE.
  - busy is therefore high for exactly k cycles. done is high for exactly one cycle, coincident with the final q.
- Serial inputs are sampled at every step edge, not only at start, so a caller may stream bits in.
- start while busy=1 is ignored entirely; opr, amt and din are don't-care.
- start in the cycle in which done=1 is accepted normally (back-to-back commands allowed).
- amt is AW bits wide, so values >= N are unrepresentable when N is a power of two. For other N, amt > N-1 is executed literally (k steps).
- done is never asserted together with busy.

Decomposition:
- Package univ_shift_pkg holds:
  - opcode localparams OP_HOLD..OP_CLEAR (3-bit)
  - FSM state encoding ST_IDLE/ST_RUN
- Sub-module shift_step: purely combinational single-step shifter (N, op, q, sin_r, sin_l -> q_next). It is shared by the RUN path and reusable by other blocks.
- The top level holds the FSM, counter and registers.

Test Plan (N=8):
- Reset then LOAD: rst low 2 cycles, then start, opr=6, din=0xB4 -> q=0xB4 next cycle, done=1 for 1 cycle, busy never 1.
- SHR by 3: from q=0xB4, start, opr=1, amt=3, sin_r=1 -> busy=1 for 3 cycles; q steps 0xDA, 0xED, 0xF6; done=1 in the cycle q=0xF6; sout_r tracks q[0].
- ASR and ROTL: from q=0x96, ASR amt=2 -> 0xCB, 0xE5. Then LOAD 0x81 and ROTL amt=7 -> final q=0xC0 after 7 busy cycles.
- Ignored start and back-to-back: during SHL amt=4, pulse start with opr=7 -> no effect, q completes the SHL. start asserted in the done cycle -> accepted.
- amt=0 and HOLD: SHR amt=0 and HOLD each -> q unchanged, done pulse 1 cycle later, busy stays 0.
- Reset mid-operation: rst=0 on the 2nd busy cycle of ROTR amt=5 -> q=0, busy=0, done=0 next cycle; no later done pulse.
